// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel PWM generator, shared counter, double-buffered period/duty
// Define PWM_MULTI_GEN_CENTER_ALIGN_EN for a center-aligned (triangle) counter; default is edge-aligned.
module pwm_multi_gen #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic                      update_i,
  output logic                      pending_o,
  output logic                      cycle_start_o,
  output logic [CHANNELS-1:0]       pwm_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          per_a_q, per_p_q;
  logic [CHANNELS*WIDTH-1:0] duty_a_q, duty_p_q;
  logic                      pending_q;
  logic                      boundary;
  logic                      apply;
  logic [CHANNELS-1:0]       cmp;

  // Since cnt never exceeds the active period, a duty above it compares true every cycle.
  always_comb begin
    cmp = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cmp[k] = en_i && (cnt_q < duty_a_q[k*WIDTH +: WIDTH]);
    end
  end

  assign apply = boundary && pending_q;

`ifdef PWM_MULTI_GEN_CENTER_ALIGN_EN
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] per_next;

  assign boundary = !en_i || (cnt_q == '0);
  assign per_next = apply ? per_p_q : per_a_q;

  // At the bottom the new period may already be in force, so a zero period pins cnt at 0.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en_i) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (cnt_q == '0) begin
      dir_d = DIR_UP;
      cnt_d = (per_next == '0) ? '0 : ONE;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == per_a_q) begin
        dir_d = DIR_DOWN;
        cnt_d = per_a_q - ONE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  assign boundary = !en_i || (cnt_q == per_a_q);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (boundary) begin
      cnt_d = '0;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      per_a_q       <= '1;
      duty_a_q      <= '0;
      per_p_q       <= '0;
      duty_p_q      <= '0;
      pending_q     <= 1'b0;
      pwm_o         <= '0;
      cycle_start_o <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pwm_o         <= cmp;
      cycle_start_o <= en_i && (cnt_q == '0);
      if (apply) begin
        per_a_q  <= per_p_q;
        duty_a_q <= duty_p_q;
      end
      // A capture on the applying boundary keeps the flag set for the following boundary.
      if (update_i) begin
        per_p_q   <= period_i;
        duty_p_q  <= duty_i;
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - directed self-checking bench for pwm_multi_gen
// Define PWM_MULTI_GEN_CENTER_ALIGN_EN to exercise the center-aligned build.
module tb_pwm_multi_gen;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            en_i;
  logic [W-1:0]    period_i;
  logic [CH*W-1:0] duty_i;
  logic            update_i;
  logic            pending_o;
  logic            cycle_start_o;
  logic [CH-1:0]   pwm_o;

  int          checks   = 0;
  int          failures = 0;
  int          hi [CH];
  int          starts;
  int          pend_cnt;
  logic [15:0] pat;
  int          n;
  int          zsum;

  pwm_multi_gen #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .period_i      (period_i),
    .duty_i        (duty_i),
    .update_i      (update_i),
    .pending_o     (pending_o),
    .cycle_start_o (cycle_start_o),
    .pwm_o         (pwm_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Samples n output cycles; optional updates of channel 1 duty at phases ua/ub.
  task automatic window(input int len, input int ua, input int da, input int ub, input int db);
    for (int k = 0; k < CH; k++) hi[k] = 0;
    starts   = 0;
    pend_cnt = 0;
    pat      = '0;
    for (int ph = 0; ph < len; ph++) begin
      for (int k = 0; k < CH; k++) hi[k] += int'(pwm_o[k]);
      starts   += int'(cycle_start_o);
      pend_cnt += int'(pending_o);
      pat[ph]   = pwm_o[1];
      update_i  = 1'b0;
      if (ph == ua) begin duty_i[15:8] = 8'(da); update_i = 1'b1; end
      if (ph == ub) begin duty_i[15:8] = 8'(db); update_i = 1'b1; end
      tick();
    end
    update_i = 1'b0;
  endtask

  initial begin
    rst_ni   = 1'b0;
    en_i     = 1'b0;
    update_i = 1'b0;
    period_i = '0;
    duty_i   = '0;
    #2;
    check("rst_pwm", 32'(pwm_o), 32'd0);
    check("rst_cs", 32'(cycle_start_o), 32'd0);
    check("rst_pend", 32'(pending_o), 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;

`ifdef PWM_MULTI_GEN_CENTER_ALIGN_EN
    period_i = 8'd4;
    duty_i   = 32'h0202_0202;
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
    window(8, -1, 0, -1, 0);
    check("ctr_hi", 32'(hi[1]), 32'd3);
    check("ctr_starts", 32'(starts), 32'd1);
    check("ctr_pat", 32'(pat[7:0]), 32'h83);
    check("ctr_cs_next", 32'(cycle_start_o), 32'd1);
    window(8, -1, 0, -1, 0);
    check("ctr_hi2", 32'(hi[1]), 32'd3);
    check("ctr_starts2", 32'(starts), 32'd1);

    period_i = 8'd0;
    duty_i   = 32'h0000_0100;
    en_i     = 1'b0;
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ctr_p0_cs", 32'(cycle_start_o), 32'd1);
      check("ctr_p0_pwm", 32'(pwm_o), 32'h2);
      tick();
    end
`else
    // Basic duties 0/3/9/10 over P=9, update captured while idle.
    period_i = 8'd9;
    duty_i   = {8'd10, 8'd9, 8'd3, 8'd0};
    update_i = 1'b1;
    tick();
    check("upd_pend", 32'(pending_o), 32'd1);
    update_i = 1'b0;
    tick();
    check("idle_apply_pend", 32'(pending_o), 32'd0);
    en_i = 1'b1;
    tick();
    check("first_cs", 32'(cycle_start_o), 32'd1);
    window(10, -1, 0, -1, 0);
    check("hi_ch0", 32'(hi[0]), 32'd0);
    check("hi_ch1", 32'(hi[1]), 32'd3);
    check("hi_ch2", 32'(hi[2]), 32'd9);
    check("hi_ch3", 32'(hi[3]), 32'd10);
    check("starts", 32'(starts), 32'd1);
    check("cs_period", 32'(cycle_start_o), 32'd1);
    window(10, -1, 0, -1, 0);
    check("hi2_ch1", 32'(hi[1]), 32'd3);
    check("hi2_ch2", 32'(hi[2]), 32'd9);
    check("starts2", 32'(starts), 32'd1);

    // Mid-period update at cnt=4.
    window(10, 3, 7, -1, 0);
    check("mid_cur", 32'(hi[1]), 32'd3);
    check("mid_pend", 32'(pend_cnt), 32'd5);
    window(10, -1, 0, -1, 0);
    check("mid_next", 32'(hi[1]), 32'd7);
    check("mid_pend_clr", 32'(pend_cnt), 32'd0);

    // Second update lands on the boundary cycle.
    window(10, 3, 5, 8, 1);
    check("bnd_cur", 32'(hi[1]), 32'd7);
    check("bnd_pend_a", 32'(pend_cnt), 32'd6);
    window(10, -1, 0, -1, 0);
    check("bnd_old", 32'(hi[1]), 32'd5);
    check("bnd_pend_b", 32'(pend_cnt), 32'd9);
    window(10, -1, 0, -1, 0);
    check("bnd_new", 32'(hi[1]), 32'd1);
    check("bnd_pend_c", 32'(pend_cnt), 32'd0);

    // Enable drop at cnt=5 with a pending update, rise 3 cycles later.
    tick();
    tick();
    duty_i[15:8] = 8'd6;
    update_i     = 1'b1;
    tick();
    update_i = 1'b0;
    check("en_pend", 32'(pending_o), 32'd1);
    tick();
    en_i = 1'b0;
    tick();
    check("idle_pwm0", 32'(pwm_o), 32'd0);
    check("idle_cs", 32'(cycle_start_o), 32'd0);
    check("idle_pend", 32'(pending_o), 32'd0);
    tick();
    check("idle_pwm1", 32'(pwm_o), 32'd0);
    tick();
    check("idle_pwm2", 32'(pwm_o), 32'd0);
    en_i = 1'b1;
    tick();
    check("rise_cs", 32'(cycle_start_o), 32'd1);
    window(10, -1, 0, -1, 0);
    check("rise_ch1", 32'(hi[1]), 32'd6);
    check("rise_ch3", 32'(hi[3]), 32'd10);
    check("rise_starts", 32'(starts), 32'd1);

    // Asynchronous reset mid-period discards a pending update.
    period_i     = 8'd20;
    duty_i[15:8] = 8'd50;
    update_i     = 1'b1;
    tick();
    update_i = 1'b0;
    tick();
    check("pre_rst_pend", 32'(pending_o), 32'd1);
    check("pre_rst_pwm", 32'(pwm_o), 32'he);
    rst_ni = 1'b0;
    #1;
    check("async_pwm", 32'(pwm_o), 32'd0);
    check("async_pend", 32'(pending_o), 32'd0);
    check("async_cs", 32'(cycle_start_o), 32'd0);
    #4;
    rst_ni = 1'b1;
    tick();
    check("post_rst_cs", 32'(cycle_start_o), 32'd1);
    n    = 0;
    zsum = 0;
    do begin
      zsum += int'(pwm_o != '0);
      tick();
      n++;
    end while (!cycle_start_o && n < 300);
    check("post_rst_period", 32'(n), 32'd256);
    check("post_rst_pwm", 32'(zsum), 32'd0);

    // P=0: every cycle is a boundary, output is (D>0).
    period_i = 8'd0;
    duty_i   = {8'd0, 8'd200, 8'd1, 8'd0};
    en_i     = 1'b0;
    update_i = 1'b1;
    tick();
    update_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("p0_cs", 32'(cycle_start_o), 32'd1);
      check("p0_pwm", 32'(pwm_o), 32'h6);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Parametrised multi-channel PWM generator for the motor/LED drive path. It succeeds the single-channel fixed-period (0..9) PWM block. All CHANNELS outputs share one WIDTH-bit period counter with a programmable period and a per-channel duty. Period and duty updates are double-buffered and take effect only at a period boundary, so no output ever sees a glitched or partial period.

## Interface
- CHANNELS, default 4: number of PWM outputs (≥1).
- WIDTH, default 8: counter, period and duty width in bits (2..16).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  run enable; low holds the generator idle.
- period_i  in  WIDTH  requested period value P (edge mode: P+1 cycles).
- duty_i  in  CHANNELS*WIDTH  requested duties; channel k uses bits [k*WIDTH +: WIDTH].
- update_i  in  1  single-cycle strobe; captures period_i/duty_i into the pending registers.
- pending_o  out  1  a captured update is waiting for the next boundary.
- cycle_start_o  out  1  pulse aligned with the first output cycle of each period.
- pwm_o  out  CHANNELS  registered PWM outputs, active-high.

## Operation
- State: counter cnt; active period P_a; active duties D_a[k]; pending copies P_p and D_p[k]; pending flag; direction flag dir (center mode only).
- Edge mode, en_i=1: cnt increments each cycle. When cnt==P_a, cnt←0; that cycle is the boundary.
- Compare: pwm_o[k] ← en_i && (cnt < D_a[k]), registered.
  - D=0: output constantly low.
  - D>P_a: output constantly high (100%).
  - Otherwise D high cycles per P_a+1.
- Boundary with pending=1: P_a←P_p, D_a←D_p, pending←0. The first cycle after the boundary uses the new values.
- update_i=1: P_p/D_p←inputs, pending←1. A repeated update before the boundary overwrites the earlier one (last write wins).
- update_i on a boundary cycle: the previously pending values apply at this boundary. The newly captured values stay pending and apply at the following boundary. pending_o stays 1.
- en_i=0:
  - cnt←0, dir←up, pwm_o←0, cycle_start_o←0.
  - Any pending update applies immediately, so every idle cycle counts as a boundary.
- cycle_start_o ← en_i && (cnt==0).
- Arithmetic: unsigned and WIDTH-bit throughout. cnt never exceeds P_a, so no modulo wrap occurs.
- P_a=0 (edge mode): every cycle is a boundary, and pwm_o[k] equals (D_a[k]>0).

## Timing
- Reset: cnt=0, dir=up, P_a=2^WIDTH−1, D_a=0, P_p=0, D_p=0, pending_o=0, pwm_o=0, cycle_start_o=0.
- Output latency: pwm_o and cycle_start_o reflect cnt with exactly 1 cycle of latency.
- pending_o goes high the cycle after update_i. It clears the cycle after the applying boundary.
- After en_i rises from idle, the first cycle_start_o and first compare result appear 1 cycle later, with cnt=0.
- Reset asserted mid-period forces all state to reset values immediately and asynchronously. Any pending update is discarded.

## Configuration
- Macro: PWM_MULTI_GEN_CENTER_ALIGN_EN.
- Defined: the counter runs as a triangle.
  - Counting up: at cnt==P_a, dir←down and cnt←P_a−1.
  - Counting down: at cnt==0, dir←up and cnt←1.
  - The boundary and pending apply happen at cnt==0 only, so the period is 2·P_a cycles.
  - The compare rule is unchanged, so pulses are symmetric about cnt==P_a.
  - With P_a=0, cnt stays at 0 and every cycle is a boundary.
- Undefined: edge-aligned sawtooth only. The dir flag is not implemented.

## Test plan
- Edge, WIDTH=8, CHANNELS=4: reset, update P=9 with D={0,3,9,10}, en=1. Each 10-cycle period shows channel highs of 0, 3, 9 and 10 cycles, and cycle_start_o pulses every 10 cycles.
- Mid-period update: P=9, D0=3, running; at cnt=4 update D0=7. pending_o=1 until the boundary. The current period keeps 3 high cycles, the next has 7, and pending_o returns to 0.
- Update on the boundary cycle (cnt==P): the old pending values apply now, the new values apply one period later, and pending_o stays 1 throughout.
- en_i drops at cnt=5, then rises 3 cycles later. pwm_o=0 while idle, a pending update applies during idle, and counting restarts at 0 with cycle_start_o one cycle after the rise.
- rst_ni pulsed low for half a clock mid-period: all outputs go to 0 immediately and P_a reads back as 255 behaviour (period of 256 cycles with duty 0).
- Center mode (macro defined): P=4, D=2. Period is 8 cycles with cnt sequence 0,1,2,3,4,3,2,1. pwm is high for cnt ∈ {0,1,1}, and cycle_start_o fires once per 8 cycles.
